// File: rtl/vector_ram_pkg.sv
// Shared types and default widths for the vector RAM writer.
// Optional write-tracking is enabled by defining ADDR_CHECK_EN.
package vector_ram_pkg;

  localparam int VR_AW = 5;
  localparam int VR_DW = 32;
  localparam int VR_CW = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } state_e;

  // Same bit layout as one {Addr, Data} line of the stimulus file
  typedef struct packed {
    logic [VR_AW-1:0] addr;
    logic [VR_DW-1:0] data;
  } vec_rec_t;

endpackage

// File: rtl/vector_ram_mem.sv
// Synchronous single-write RAM with a registered, read-first read port.
// The array itself is never reset; only the read register clears.
module vector_ram_mem #(
  parameter int AW = 5,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [2**AW];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Separate process keeps same-address access returning the pre-write value
  always_ff @(posedge clk) begin
    if (!reset) begin
      rdata <= '0;
    end else begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/vector_ram_writer.sv
// Loads {addr,data} records over valid/ready into RAM and exposes a ROM-style read port.
// Define ADDR_CHECK_EN to track written entries and count rewrites in err_count.
//
// state | meaning
// IDLE  | waiting for the first record of a load
// LOAD  | first record accepted, last not yet seen
// DONE  | last record accepted; input closed until reset
module vector_ram_writer
  import vector_ram_pkg::*;
#(
  parameter int AW = VR_AW,
  parameter int DW = VR_DW,
  parameter int CW = VR_CW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [AW-1:0] in_addr,
  input  logic [DW-1:0] in_data,
  input  logic          in_last,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_data,
  output logic          rd_written,
  output logic          busy,
  output logic          done,
  output logic [CW-1:0] wr_count,
  output logic [CW-1:0] err_count
);

  state_e   state, state_nx;
  vec_rec_t rec;
  logic     xfer;

  assign rec.addr = in_addr;
  assign rec.data = in_data;

  assign in_ready = (state != DONE) && reset;
  assign xfer     = in_valid && in_ready;
  assign busy     = (state == LOAD);
  assign done     = (state == DONE);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE, LOAD: begin
        if (xfer) begin
          state_nx = in_last ? DONE : LOAD;
        end
      end
      DONE:    state_nx = DONE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_count <= '0;
    end else if (xfer && (wr_count != '1)) begin
      wr_count <= wr_count + CW'(1);
    end
  end

  vector_ram_mem #(
    .AW(AW),
    .DW(DW)
  ) u_mem (
    .clk   (clk),
    .reset (reset),
    .we    (xfer),
    .waddr (rec.addr),
    .wdata (rec.data),
    .raddr (rd_addr),
    .rdata (rd_data)
  );

`ifdef ADDR_CHECK_EN
  logic [2**AW-1:0] written;

  always_ff @(posedge clk) begin
    if (!reset) begin
      written <= '0;
    end else if (xfer) begin
      written[rec.addr] <= 1'b1;
    end
  end

  // A rewrite is still stored; it is only counted as an error
  always_ff @(posedge clk) begin
    if (!reset) begin
      err_count <= '0;
    end else if (xfer && written[rec.addr] && (err_count != '1)) begin
      err_count <= err_count + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      rd_written <= 1'b0;
    end else begin
      rd_written <= written[rd_addr];
    end
  end
`else
  assign err_count = '0;

  always_ff @(posedge clk) begin
    if (!reset) begin
      rd_written <= 1'b0;
    end else begin
      rd_written <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_vector_ram_writer.sv
// Self-checking bench for vector_ram_writer: directed loads against a behavioural model.
// Build with or without ADDR_CHECK_EN; expectations follow the macro.
module tb_vector_ram_writer;

  localparam int AW = 5;
  localparam int DW = 32;
  localparam int CW = 32;
  localparam int DEPTH = 2**AW;

`ifdef ADDR_CHECK_EN
  localparam bit CHECK = 1'b1;
`else
  localparam bit CHECK = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [AW-1:0] in_addr = '0;
  logic [DW-1:0] in_data = '0;
  logic          in_last = 1'b0;
  logic [AW-1:0] rd_addr = '0;
  logic [DW-1:0] rd_data;
  logic          rd_written;
  logic          busy;
  logic          done;
  logic [CW-1:0] wr_count;
  logic [CW-1:0] err_count;

  int n_checks = 0;
  int n_errors = 0;

  vector_ram_writer #(.AW(AW), .DW(DW), .CW(CW)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_addr    (in_addr),
    .in_data    (in_data),
    .in_last    (in_last),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .rd_written (rd_written),
    .busy       (busy),
    .done       (done),
    .wr_count   (wr_count),
    .err_count  (err_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Behavioural model: a load is "open" until a last record, then closed until reset
  logic [DW-1:0] m_mem   [DEPTH];
  bit            m_known [DEPTH];
  bit            m_wrote [DEPTH];
  bit            m_init = 0;
  bit            m_loading, m_closed;
  longint        m_accepted, m_rewrites;
  logic [DW-1:0] m_rd;
  bit            m_rd_known;
  bit            m_rdw;

  always @(posedge clk) begin
    if (!reset) begin
      m_init     = 1;
      m_loading  = 0;
      m_closed   = 0;
      m_accepted = 0;
      m_rewrites = 0;
      m_rd       = '0;
      m_rd_known = 1;
      m_rdw      = 0;
      for (int i = 0; i < DEPTH; i++) m_wrote[i] = 0;
    end else begin
      m_rd       = m_mem[rd_addr];
      m_rd_known = m_known[rd_addr];
      m_rdw      = CHECK ? m_wrote[rd_addr] : 1'b1;
      if (in_valid && !m_closed) begin
        if (m_wrote[in_addr]) m_rewrites++;
        m_wrote[in_addr] = 1;
        m_mem[in_addr]   = in_data;
        m_known[in_addr] = 1;
        m_accepted++;
        if (in_last) begin
          m_closed  = 1;
          m_loading = 0;
        end else begin
          m_loading = 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (m_init) begin
      chk("in_ready", in_ready, !m_closed && reset);
      chk("busy", busy, m_loading);
      chk("done", done, m_closed);
      chk("wr_count", wr_count, m_accepted);
      chk("err_count", err_count, CHECK ? m_rewrites : 0);
      chk("rd_written", rd_written, m_rdw);
      if (m_rd_known) chk("rd_data", rd_data, m_rd);
    end
  end

  task automatic wr_rec(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic l);
    in_valid = 1'b1;
    in_addr  = a;
    in_data  = d;
    in_last  = l;
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      m_known[i] = 0;
      m_mem[i]   = '0;
    end

    // 1: reset held two cycles
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    chk("t1_in_ready", in_ready, 1);
    chk("t1_busy", busy, 0);
    chk("t1_done", done, 0);
    chk("t1_wr_count", wr_count, 0);
    chk("t1_err_count", err_count, 0);
    chk("t1_rd_data", rd_data, 0);
    chk("t1_rd_written", rd_written, 0);

    // 2: single write, read back next cycle
    @(posedge clk); #1;
    rd_addr = 3;
    wr_rec(3, 32'hDEADBEEF, 0);
    in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("t2_rd_data", rd_data, 32'hDEADBEEF);
    chk("t2_busy", busy, 1);

    // 6: rewrite of address 5, then probe written flags at 5 and 6
    wr_rec(5, 32'h11111111, 0);
    wr_rec(5, 32'h22222222, 0);
    in_valid = 1'b0;
    rd_addr  = 5;
    @(posedge clk);
    @(negedge clk);
    chk("t6_err_count", err_count, CHECK ? 1 : 0);
    chk("t6_rd_written_5", rd_written, 1);
    chk("t6_rd_data_5", rd_data, 32'h22222222);
    rd_addr = 6;
    @(posedge clk);
    @(negedge clk);
    chk("t6_rd_written_6", rd_written, CHECK ? 0 : 1);

    // 4: read-during-write on address 7 returns old data
    #1;
    wr_rec(7, 32'h0, 0);
    rd_addr = 7;
    wr_rec(7, 32'h7, 0);
    in_valid = 1'b0;
    @(negedge clk);
    chk("t4_rd_old", rd_data, 32'h0);
    @(negedge clk);
    chk("t4_rd_new", rd_data, 32'h7);

    // 5: reset mid-load after 10 records
    #1;
    for (int i = 10; i < 15; i++) wr_rec(AW'(i), 32'hA0000000 | i, 0);
    in_valid = 1'b0;
    @(negedge clk);
    chk("t5_pre_wr_count", wr_count, 10);
    #1 reset = 1'b0;
    @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    chk("t5_busy", busy, 0);
    chk("t5_wr_count", wr_count, 0);
    chk("t5_in_ready", in_ready, 1);

    // 3: full 32-record load
    #1;
    for (int i = 0; i < DEPTH; i++) wr_rec(AW'(i), i * 32'h01010101, i == DEPTH - 1);
    in_valid = 1'b0;
    @(negedge clk);
    chk("t3_wr_count", wr_count, 32);
    chk("t3_done", done, 1);
    chk("t3_in_ready", in_ready, 0);
    chk("t3_err_count", err_count, 0);
    for (int i = 0; i < DEPTH; i++) begin
      #1 rd_addr = AW'(i);
      @(negedge clk);
    end
    @(negedge clk);
    chk("t3_rd_31", rd_data, 32'h1F1F1F1F);
    #1;
    wr_rec(0, 32'hFFFFFFFF, 0);
    in_valid = 1'b0;
    rd_addr  = 0;
    @(negedge clk);
    chk("t3_extra_wr_count", wr_count, 32);
    @(negedge clk);
    chk("t3_rd_0_kept", rd_data, 32'h0);

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
